// File: rtl/fft_seq_pkg.sv
// Shared types and defaults for the radix-2 stage frame sequencer.
package fft_seq_pkg;

  localparam int DEF_FRAME_BLKS = 32;
  localparam int DEF_LAT        = 2;
  localparam int MAX_IDX_W      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  // One slot of the output-side delay line; idx is sized for the largest frame.
  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
    logic                 last;
  } dl_entry_t;

endpackage

// File: rtl/fft_stage_seq_if.sv
// Control/status bundle between the upstream stream source and the stage sequencer.
interface fft_stage_seq_if #(
  parameter int IDX_W = 5
);
  logic             start_i;
  logic             clr_err_i;
  logic             stage_en_o;
  logic [IDX_W-1:0] blk_idx_o;
  logic             first_o;
  logic             last_o;
  logic             dout_valid_o;
  logic [IDX_W-1:0] dout_idx_o;
  logic             frame_done_o;
  logic [15:0]      frame_cnt_o;
  logic             busy_o;
  logic             overrun_o;

  modport master (
    output start_i, clr_err_i,
    input  stage_en_o, blk_idx_o, first_o, last_o, dout_valid_o, dout_idx_o,
           frame_done_o, frame_cnt_o, busy_o, overrun_o
  );

  modport slave (
    input  start_i, clr_err_i,
    output stage_en_o, blk_idx_o, first_o, last_o, dout_valid_o, dout_idx_o,
           frame_done_o, frame_cnt_o, busy_o, overrun_o
  );
endinterface

// File: rtl/seq_delay_line.sv
// Resettable LAT-deep shift register that mirrors the butterfly pipeline latency.
module seq_delay_line
  import fft_seq_pkg::*;
#(
  parameter int  LAT     = DEF_LAT,
  parameter type entry_t = dl_entry_t
) (
  input  logic   clk,
  input  logic   rstn,
  input  entry_t din,
  output entry_t dout,
  output logic   any_valid
);

  entry_t [LAT-1:0] stages;

  // Shift one slot per clock; reset empties the whole line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stages <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < LAT; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign dout = stages[LAT-1];

  // Valid entries that will still sit in the line after the next shift
  // (everything upstream of the output slot).
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      any_valid = any_valid | stages[i].valid;
    end
  end

endmodule

// File: rtl/fft_stage_seq.sv
// Frame sequencer: start strobe -> per-frame enable window, delayed output valid/index,
// frame completion count and sticky overrun flag.
module fft_stage_seq
  import fft_seq_pkg::*;
#(
  parameter int FRAME_BLKS = DEF_FRAME_BLKS,
  parameter int LAT        = DEF_LAT,
  parameter int IDX_W      = $clog2(FRAME_BLKS)
) (
  input logic            clk,
  input logic            rstn,
  fft_stage_seq_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BLKS - 1);

  seq_state_e       state;
  logic [IDX_W-1:0] cnt;
  logic             start;
  logic             in_run;
  logic             at_last;
  logic             stage_en;
  logic [IDX_W-1:0] blk_idx;
  logic             illegal_start;
  dl_entry_t        dl_in;
  dl_entry_t        dl_out;
  logic             dl_pending;
  logic [IDX_W-1:0] held_idx;
  logic [15:0]      frame_cnt;
  logic             overrun;
  logic             unused_idx_bits;

  // Block 0 arrives together with the strobe, so enable is Mealy on start outside RUN.
  assign start         = bus.start_i & rstn;
  assign in_run        = (state == RUN);
  assign stage_en      = in_run | start;
  assign blk_idx       = in_run ? cnt : '0;
  assign at_last       = in_run && (cnt == LAST_IDX);
  assign illegal_start = in_run && start && !at_last;

  // Frame FSM and block counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            cnt   <= IDX_W'(1);
          end
        end
        RUN: begin
          if (cnt == LAST_IDX) begin
            cnt <= '0;
            if (!start) state <= DRAIN;
          end else begin
            cnt <= cnt + IDX_W'(1);
          end
        end
        DRAIN: begin
          if (start) begin
            state <= RUN;
            cnt   <= IDX_W'(1);
          end else if (!dl_pending) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    dl_in       = '0;
    dl_in.valid = stage_en;
    dl_in.idx   = MAX_IDX_W'(blk_idx);
    dl_in.last  = at_last;
  end

  seq_delay_line #(
    .LAT     (LAT),
    .entry_t (dl_entry_t)
  ) u_delay (
    .clk       (clk),
    .rstn      (rstn),
    .din       (dl_in),
    .dout      (dl_out),
    .any_valid (dl_pending)
  );

  // Index bits above IDX_W are always zero for this frame size.
  assign unused_idx_bits = ^dl_out.idx;

  // Remember the last delivered index so dout_idx_o holds between frames.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) held_idx <= '0;
    else if (dl_out.valid) held_idx <= dl_out.idx[IDX_W-1:0];
  end

  // Count frames once their last block has left the stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) frame_cnt <= '0;
    else if (dl_out.valid && dl_out.last) frame_cnt <= frame_cnt + 16'd1;
  end

  // Sticky overrun; a new violation beats a simultaneous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) overrun <= 1'b0;
    else if (illegal_start) overrun <= 1'b1;
    else if (bus.clr_err_i) overrun <= 1'b0;
  end

  assign bus.stage_en_o   = stage_en;
  assign bus.blk_idx_o    = blk_idx;
  assign bus.first_o      = stage_en && (blk_idx == '0);
  assign bus.last_o       = at_last;
  assign bus.dout_valid_o = dl_out.valid;
  assign bus.dout_idx_o   = dl_out.valid ? dl_out.idx[IDX_W-1:0] : held_idx;
  assign bus.frame_done_o = dl_out.valid && dl_out.last;
  assign bus.frame_cnt_o  = frame_cnt;
  assign bus.busy_o       = (state != IDLE) || start;
  assign bus.overrun_o    = overrun;

endmodule

// File: tb/tb_fft_stage_seq.sv
// Directed bench for fft_stage_seq: default 32/2 instance plus a 4-block, LAT=1 instance.
module tb_fft_stage_seq;

  typedef struct {
    int en;
    int idx;
    int first;
    int last;
    int dv;
    int didx;
    int fd;
    int fc;
    int busy;
    int ovr;
  } obs_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cycNow      = 0;

  obs_t obsMain;
  obs_t obsSmall;
  obs_t e;

  always #5 clk = ~clk;

  fft_stage_seq_if #(.IDX_W(5)) main_bus ();
  fft_stage_seq_if #(.IDX_W(2)) small_bus ();

  fft_stage_seq #(.FRAME_BLKS(32), .LAT(2), .IDX_W(5)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (main_bus.slave)
  );

  fft_stage_seq #(.FRAME_BLKS(4), .LAT(1), .IDX_W(2)) dut_small (
    .clk  (clk),
    .rstn (rstn),
    .bus  (small_bus.slave)
  );

  // Snapshot both instances' outputs as plain integers.
  always_comb begin
    obsMain.en    = int'(main_bus.stage_en_o);
    obsMain.idx   = int'(main_bus.blk_idx_o);
    obsMain.first = int'(main_bus.first_o);
    obsMain.last  = int'(main_bus.last_o);
    obsMain.dv    = int'(main_bus.dout_valid_o);
    obsMain.didx  = int'(main_bus.dout_idx_o);
    obsMain.fd    = int'(main_bus.frame_done_o);
    obsMain.fc    = int'(main_bus.frame_cnt_o);
    obsMain.busy  = int'(main_bus.busy_o);
    obsMain.ovr   = int'(main_bus.overrun_o);
    obsSmall.en    = int'(small_bus.stage_en_o);
    obsSmall.idx   = int'(small_bus.blk_idx_o);
    obsSmall.first = int'(small_bus.first_o);
    obsSmall.last  = int'(small_bus.last_o);
    obsSmall.dv    = int'(small_bus.dout_valid_o);
    obsSmall.didx  = int'(small_bus.dout_idx_o);
    obsSmall.fd    = int'(small_bus.frame_done_o);
    obsSmall.fc    = int'(small_bus.frame_cnt_o);
    obsSmall.busy  = int'(small_bus.busy_o);
    obsSmall.ovr   = int'(small_bus.overrun_o);
  end

  task automatic checkOutput(input string tag, input int act, input int expv);
    testsRun++;
    if (act !== expv) begin
      testsFailed++;
      $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", tag, cycNow, act, expv);
    end
  endtask

  task automatic checkObs(input string pfx, input obs_t o, input obs_t x,
                          input bit chkIdx, input bit chkDidx);
    checkOutput({pfx, ".stage_en"}, o.en, x.en);
    if (chkIdx) checkOutput({pfx, ".blk_idx"}, o.idx, x.idx);
    checkOutput({pfx, ".first"}, o.first, x.first);
    checkOutput({pfx, ".last"}, o.last, x.last);
    checkOutput({pfx, ".dout_valid"}, o.dv, x.dv);
    if (chkDidx) checkOutput({pfx, ".dout_idx"}, o.didx, x.didx);
    checkOutput({pfx, ".frame_done"}, o.fd, x.fd);
    checkOutput({pfx, ".frame_cnt"}, o.fc, x.fc);
    checkOutput({pfx, ".busy"}, o.busy, x.busy);
    checkOutput({pfx, ".overrun"}, o.ovr, x.ovr);
  endtask

  // Drive this cycle's inputs just after the edge, then settle to the falling edge.
  task automatic applyStimulus(input logic st, input logic clr, input logic stSmall);
    main_bus.start_i   = st;
    main_bus.clr_err_i = clr;
    small_bus.start_i  = stSmall;
    small_bus.clr_err_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    main_bus.start_i    = 1'b0;
    main_bus.clr_err_i  = 1'b0;
    small_bus.start_i   = 1'b0;
    small_bus.clr_err_i = 1'b0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  function automatic obs_t zeroObs();
    obs_t z;
    z = '{default: 0};
    return z;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog cycle %0d: got timeout expected finish", cycNow);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values on both instances while reset is held.
    $display("[TB] reset values");
    resetDut();
    rstn = 1'b0;
    #1;
    checkObs("rst_main", obsMain, zeroObs(), 1'b1, 1'b1);
    checkObs("rst_small", obsSmall, zeroObs(), 1'b1, 1'b1);

    // Single frame.
    $display("[TB] single frame");
    resetDut();
    for (int c = 0; c <= 50; c++) begin
      cycNow = c;
      applyStimulus(c == 10, 1'b0, 1'b0);
      e.en    = int'(c >= 10 && c <= 41);
      e.idx   = c - 10;
      e.first = int'(c == 10);
      e.last  = int'(c == 41);
      e.dv    = int'(c >= 12 && c <= 43);
      e.didx  = (c <= 43) ? c - 12 : 31;
      e.fd    = int'(c == 43);
      e.fc    = int'(c >= 44);
      e.busy  = int'(c >= 10 && c <= 43);
      e.ovr   = 0;
      checkObs("single", obsMain, e, e.en != 0, (e.dv != 0) || (c > 43));
      nextCycle();
    end

    // Back-to-back frames.
    $display("[TB] back-to-back");
    resetDut();
    for (int c = 0; c <= 80; c++) begin
      cycNow = c;
      applyStimulus(c == 10 || c == 42, 1'b0, 1'b0);
      e.en    = int'(c >= 10 && c <= 73);
      e.idx   = (c < 42) ? c - 10 : c - 42;
      e.first = int'(c == 10 || c == 42);
      e.last  = int'(c == 41 || c == 73);
      e.dv    = int'(c >= 12 && c <= 75);
      e.didx  = (c < 44) ? c - 12 : c - 44;
      e.fd    = int'(c == 43 || c == 75);
      e.fc    = (c < 44) ? 0 : ((c < 76) ? 1 : 2);
      e.busy  = int'(c >= 10 && c <= 75);
      e.ovr   = 0;
      checkObs("b2b", obsMain, e, e.en != 0, e.dv != 0);
      nextCycle();
    end

    // Illegal starts, clear, and clear colliding with a new violation.
    $display("[TB] overrun");
    resetDut();
    for (int c = 0; c <= 75; c++) begin
      cycNow = c;
      applyStimulus(c == 10 || c == 20 || c == 60 || c == 65 || c == 70,
                    c == 50 || c == 70, 1'b0);
      e.en    = int'((c >= 10 && c <= 41) || c >= 60);
      e.idx   = (c < 42) ? c - 10 : c - 60;
      e.first = int'(c == 10 || c == 60);
      e.last  = int'(c == 41);
      e.dv    = int'((c >= 12 && c <= 43) || c >= 62);
      e.didx  = (c < 44) ? c - 12 : c - 62;
      e.fd    = int'(c == 43);
      e.fc    = int'(c >= 44);
      e.busy  = int'((c >= 10 && c <= 43) || c >= 60);
      e.ovr   = int'((c >= 21 && c <= 50) || c >= 66);
      checkObs("ovr", obsMain, e, e.en != 0, e.dv != 0);
      nextCycle();
    end

    // New start while the previous tail drains.
    $display("[TB] start during drain");
    resetDut();
    for (int c = 0; c <= 85; c++) begin
      cycNow = c;
      applyStimulus(c == 10 || c == 43, 1'b0, 1'b0);
      e.en    = int'((c >= 10 && c <= 41) || (c >= 43 && c <= 74));
      e.idx   = (c < 42) ? c - 10 : c - 43;
      e.first = int'(c == 10 || c == 43);
      e.last  = int'(c == 41 || c == 74);
      e.dv    = int'((c >= 12 && c <= 43) || (c >= 45 && c <= 76));
      e.didx  = (c < 44) ? c - 12 : c - 45;
      e.fd    = int'(c == 43 || c == 76);
      e.fc    = (c < 44) ? 0 : ((c < 77) ? 1 : 2);
      e.busy  = int'(c >= 10 && c <= 76);
      e.ovr   = 0;
      checkObs("drain", obsMain, e, e.en != 0, e.dv != 0);
      nextCycle();
    end

    // Reset mid-frame (frame count is 2 from the previous run).
    $display("[TB] reset mid-frame");
    for (int c = 0; c <= 70; c++) begin
      cycNow = c;
      rstn = !(c >= 20 && c <= 22);
      applyStimulus(c == 10 || c == 30, 1'b0, 1'b0);
      e.en    = int'((c >= 10 && c <= 19) || (c >= 30 && c <= 61));
      e.idx   = (c < 20) ? c - 10 : c - 30;
      e.first = int'(c == 10 || c == 30);
      e.last  = int'(c == 61);
      e.dv    = int'((c >= 12 && c <= 19) || (c >= 32 && c <= 63));
      e.didx  = (c < 20) ? c - 12 : ((c < 32) ? 0 : c - 32);
      e.fd    = int'(c == 63);
      e.fc    = (c < 20) ? 2 : ((c < 64) ? 0 : 1);
      e.busy  = int'((c >= 10 && c <= 19) || (c >= 30 && c <= 63));
      e.ovr   = 0;
      checkObs("midrst", obsMain, e, e.en != 0, (e.dv != 0) || (c >= 20 && c < 32));
      nextCycle();
    end
    rstn = 1'b1;

    // Small instance: 4 blocks, latency 1.
    $display("[TB] small frame");
    resetDut();
    for (int c = 0; c <= 15; c++) begin
      cycNow = c;
      applyStimulus(1'b0, 1'b0, c == 5);
      e.en    = int'(c >= 5 && c <= 8);
      e.idx   = c - 5;
      e.first = int'(c == 5);
      e.last  = int'(c == 8);
      e.dv    = int'(c >= 6 && c <= 9);
      e.didx  = c - 6;
      e.fd    = int'(c == 9);
      e.fc    = int'(c >= 10);
      e.busy  = int'(c >= 5 && c <= 9);
      e.ovr   = 0;
      checkObs("small", obsSmall, e, e.en != 0, e.dv != 0);
      nextCycle();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
